reg_bank: RTL

//  Parametrised bank of NREGS general-purpose registers, WIDTH bits each; next-generation replacement for single registers.
//  One bus write port (active-low load), one step port (increment/decrement, for PC/SP-style use), two async read ports.

---
 rtl/regbank_pkg.sv | 24 ++
 rtl/reg_bank_if.sv | 34 +++
 rtl/reg_bank_cell.sv | 38 +++
 rtl/reg_bank.sv | 86 ++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and the step wrap predicate for the register bank.
package regbank_pkg;

  localparam logic STEP_UP = 1'b0;
  localparam logic STEP_DN = 1'b1;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NREGS = 4;
  localparam int unsigned DEF_STEP  = 1;

  // True when stepping `old` by `step` crosses the 2^width modulus (width <= 64).
  function automatic logic step_wraps(logic [63:0] old, int unsigned width,
                                      int unsigned step, logic dn);
    logic [64:0] sum;
    logic [64:0] lim;
    if (dn == STEP_DN) begin
      return old < 64'(step);
    end
    sum = 65'(old) + 65'(step);
    lim = 65'(1) << width;
    return sum >= lim;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Bus-side signal bundle of the register bank: write/step strobes, read selects and results.
interface reg_bank_if
  import regbank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = DEF_NREGS
) ();

  localparam int unsigned AW = $clog2(NREGS);

  logic [WIDTH-1:0] bus;
  logic             load_bar;
  logic [AW-1:0]    wr_sel;
  logic             step_bar;
  logic [AW-1:0]    step_sel;
  logic             step_dn;
  logic [AW-1:0]    rd_a_sel;
  logic [AW-1:0]    rd_b_sel;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             wrap;
  logic [NREGS-1:0] written;

  modport master (
    output bus, load_bar, wr_sel, step_bar, step_sel, step_dn, rd_a_sel, rd_b_sel,
    input  rd_a, rd_b, wrap, written
  );

  modport slave (
    input  bus, load_bar, wr_sel, step_bar, step_sel, step_dn, rd_a_sel, rd_b_sel,
    output rd_a, rd_b, wrap, written
  );

endinterface

// File: rtl/reg_bank_cell.sv
// One bank register: load beats step; step adds or subtracts STEP modulo 2^WIDTH.
module reg_bank_cell
  import regbank_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      STEP      = DEF_STEP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             load,
  input  logic             step,
  input  logic             step_dn,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value,
  output logic             wrap_next
);

  logic [WIDTH-1:0] step_val;

  // Stepped value and whether that step crosses the modulus.
  always_comb begin
    step_val  = (step_dn == STEP_DN) ? value - WIDTH'(STEP) : value + WIDTH'(STEP);
    wrap_next = step && step_wraps(64'(value), WIDTH, STEP, step_dn);
  end

  // Register state with asynchronous reset.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= data;
    end else if (step) begin
      value <= step_val;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Register bank: NREGS x WIDTH registers, one load port, one step port, two async read ports.
// Optional build macro REGBANK_BYPASS_EN: a read selecting the register being loaded
// returns the bus value in the same cycle (loads only, never step results).
module reg_bank
  import regbank_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      NREGS     = DEF_NREGS,
  parameter int unsigned      STEP      = DEF_STEP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic     clk,
  input logic     reset_bar,
  reg_bank_if.slave bank
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-1:0] load_vec;
  logic [NREGS-1:0] step_vec;
  logic [NREGS-1:0] wrap_vec;
  logic [WIDTH-1:0] vals [NREGS];
  logic [WIDTH-1:0] rd_a_c;
  logic [WIDTH-1:0] rd_b_c;
  logic             wrap_q;
  logic [NREGS-1:0] written_q;

  // Select decode; out-of-range selects match no register. Load wins over step on the same register.
  always_comb begin
    load_vec = '0;
    step_vec = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      load_vec[i] = !bank.load_bar && (bank.wr_sel == AW'(i));
      step_vec[i] = !bank.step_bar && (bank.step_sel == AW'(i)) && !load_vec[i];
    end
  end

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_cell
    reg_bank_cell #(
      .WIDTH     (WIDTH),
      .STEP      (STEP),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk       (clk),
      .reset_bar (reset_bar),
      .load      (load_vec[g]),
      .step      (step_vec[g]),
      .step_dn   (bank.step_dn),
      .data      (bank.bus),
      .value     (vals[g]),
      .wrap_next (wrap_vec[g])
    );
  end

  // Read muxes; unmatched selects read as zero.
  always_comb begin
    rd_a_c = '0;
    rd_b_c = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
`ifdef REGBANK_BYPASS_EN
      if (bank.rd_a_sel == AW'(i)) rd_a_c = load_vec[i] ? bank.bus : vals[i];
      if (bank.rd_b_sel == AW'(i)) rd_b_c = load_vec[i] ? bank.bus : vals[i];
`else
      if (bank.rd_a_sel == AW'(i)) rd_a_c = vals[i];
      if (bank.rd_b_sel == AW'(i)) rd_b_c = vals[i];
`endif
    end
  end

  // One-cycle wrap pulse and sticky per-register loaded flags.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      wrap_q    <= 1'b0;
      written_q <= '0;
    end else begin
      wrap_q    <= |wrap_vec;
      written_q <= written_q | load_vec;
    end
  end

  assign bank.rd_a    = rd_a_c;
  assign bank.rd_b    = rd_b_c;
  assign bank.wrap    = wrap_q;
  assign bank.written = written_q;

endmodule
